// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the IF fetch
// port and the MEM load/store port using a req/ack handshake.
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr      -> fetch request;  if_ack/if_rdata/if_stall back to IF
//   dm_req/dm_we/dm_addr/dm_wdata/dm_size/dm_unsigned -> load/store request;
//                          dm_ack/dm_rdata/dm_stall back to MEM
//   mem_req/mem_we/mem_addr/mem_wdata/mem_size/mem_unsigned -> memory request
//   mem_ack/mem_rdata   <- memory completion
//   timeout_err         sticky watchdog-abort flag
// The data port has priority; a streak counter forces a fetch after
// MAX_DM_STREAK consecutive data grants that starved a pending fetch.
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_size,
  input  logic        dm_unsigned,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  output logic        mem_unsigned,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  localparam int unsigned WD_W = 8;
  localparam int unsigned ST_W = 4;
  localparam logic [2:0]  SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY_IF = 3'd1,
    S_BUSY_DM = 3'd2,
    S_DONE_IF = 3'd3,
    S_DONE_DM = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ST_W-1:0]   streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_size_q, mem_size_d;
  logic              mem_unsigned_q, mem_unsigned_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              timeout_err_q, timeout_err_d;

  logic force_if_c, grant_dm_c, grant_if_c, timeout_hit_c;

  // Arbitration: DM wins unless a waiting fetch has been starved long enough.
  assign force_if_c    = if_req && (streak_q == ST_W'(MAX_DM_STREAK));
  assign grant_dm_c    = (state_q == S_IDLE) && dm_req && !force_if_c;
  assign grant_if_c    = (state_q == S_IDLE) && !grant_dm_c && if_req;
  assign timeout_hit_c = (wd_q == WD_W'(TIMEOUT - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      wd_q           <= '0;
      streak_q       <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_size_q     <= '0;
      mem_unsigned_q <= 1'b0;
      if_ack_q       <= 1'b0;
      dm_ack_q       <= 1'b0;
      if_rdata_q     <= '0;
      dm_rdata_q     <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      streak_q       <= streak_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_size_q     <= mem_size_d;
      mem_unsigned_q <= mem_unsigned_d;
      if_ack_q       <= if_ack_d;
      dm_ack_q       <= dm_ack_d;
      if_rdata_q     <= if_rdata_d;
      dm_rdata_q     <= dm_rdata_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_dm_c)      state_d = S_BUSY_DM;
        else if (grant_if_c) state_d = S_BUSY_IF;
      end
      S_BUSY_IF: if (mem_ack || timeout_hit_c) state_d = S_DONE_IF;
      S_BUSY_DM: if (mem_ack || timeout_hit_c) state_d = S_DONE_DM;
      S_DONE_IF, S_DONE_DM: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register next values: grant latching, completion capture, watchdog, streak.
  always_comb begin
    wd_d           = wd_q;
    streak_d       = streak_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_size_d     = mem_size_q;
    mem_unsigned_d = mem_unsigned_q;
    if_ack_d       = 1'b0;
    dm_ack_d       = 1'b0;
    if_rdata_d     = if_rdata_q;
    dm_rdata_d     = dm_rdata_q;
    timeout_err_d  = timeout_err_q;
    unique case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (grant_dm_c) begin
          mem_req_d      = 1'b1;
          mem_we_d       = dm_we;
          mem_addr_d     = dm_addr;
          mem_wdata_d    = dm_wdata;
          mem_size_d     = dm_size;
          mem_unsigned_d = dm_unsigned;
          // Count only grants that kept a fetch waiting; saturate at the limit.
          if (!if_req)
            streak_d = '0;
          else if (streak_q != ST_W'(MAX_DM_STREAK))
            streak_d = streak_q + ST_W'(1);
        end else if (grant_if_c) begin
          mem_req_d      = 1'b1;
          mem_we_d       = 1'b0;
          mem_addr_d     = if_addr;
          mem_wdata_d    = '0;
          mem_size_d     = SIZE_WORD;
          mem_unsigned_d = 1'b0;
          streak_d       = '0;
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (mem_ack || timeout_hit_c) begin
          mem_req_d = 1'b0;
          if (!mem_ack) timeout_err_d = 1'b1;
          if (state_q == S_BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : 32'h0;
          end else begin
            dm_ack_d = 1'b1;
            // Completed stores leave the load data untouched; aborts zero it.
            if (!mem_ack)       dm_rdata_d = 32'h0;
            else if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DONE_IF, S_DONE_DM: wd_d = '0;
      default: ;
    endcase
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_size     = mem_size_q;
  assign mem_unsigned = mem_unsigned_q;
  assign if_ack       = if_ack_q;
  assign dm_ack       = dm_ack_q;
  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;
  assign timeout_err  = timeout_err_q;
  assign if_stall     = if_req & ~if_ack_q;
  assign dm_stall     = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed requester/memory stimulus, a
// transaction-level model checked every cycle, and hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int unsigned MAXS = 4;
  localparam int unsigned TMO  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_unsigned, dm_ack, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_size;
  logic        mem_req, mem_we, mem_unsigned, mem_ack, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_size;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_unsigned(dm_unsigned), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  // Model: who owns the memory, how long it has waited, and the visible outputs.
  int          m_owner;   // 0 none, 1 fetch, 2 data
  int          m_wait;
  int          m_streak;
  bit          m_mem_req, m_we, m_uns, m_if_ack, m_dm_ack, m_terr;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic [2:0]  m_size;

  // Memory responder and observation log.
  int ack_delay = 0;
  int req_age = 0;
  bit spurious = 1'b0;
  int cyc = 0;
  int last_obs = 0;
  bit seen_if_ack, seen_dm_ack, prev_mem_req;
  logic [31:0] rise_addr[$];
  logic [31:0] rise_wdata[$];
  bit          rise_we[$];
  logic [2:0]  rise_size[$];
  int          rise_cyc[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_streak = 0;
    m_mem_req = 0; m_we = 0; m_uns = 0; m_if_ack = 0; m_dm_ack = 0; m_terr = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0; m_size = '0;
  endtask

  task automatic compare_all();
    chk("mem_req", 32'(mem_req), 32'(m_mem_req));
    chk("if_ack", 32'(if_ack), 32'(m_if_ack));
    chk("dm_ack", 32'(dm_ack), 32'(m_dm_ack));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("if_stall", 32'(if_stall), 32'(if_req & ~m_if_ack));
    chk("dm_stall", 32'(dm_stall), 32'(dm_req & ~m_dm_ack));
    if (m_mem_req) begin
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_size", 32'(mem_size), 32'(m_size));
      chk("mem_unsigned", 32'(mem_unsigned), 32'(m_uns));
    end
  endtask

  task automatic finish_access(input bit ok);
    logic [31:0] v;
    v = ok ? mem_rd(m_addr) : 32'h0;
    if (!ok) m_terr = 1;
    if (m_owner == 1) begin m_if_ack = 1; m_if_rdata = v; end
    else begin m_dm_ack = 1; if (!ok || !m_we) m_dm_rdata = v; end
    m_owner = 0; m_mem_req = 0;
  endtask

  // One access costs a grant cycle, >=1 memory cycle and an acknowledge cycle.
  task automatic model_step();
    if (m_if_ack || m_dm_ack) begin
      m_if_ack = 0; m_dm_ack = 0;
    end else if (m_owner == 0) begin
      if (dm_req && !(if_req && m_streak == int'(MAXS))) begin
        m_owner = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        m_size = dm_size; m_uns = dm_unsigned; m_mem_req = 1; m_wait = 0;
        m_streak = if_req ? ((m_streak < int'(MAXS)) ? m_streak + 1 : m_streak) : 0;
      end else if (if_req) begin
        m_owner = 1; m_we = 0; m_addr = if_addr; m_wdata = '0;
        m_size = 3'b010; m_uns = 0; m_mem_req = 1; m_wait = 0; m_streak = 0;
      end
    end else begin
      if (mem_ack) finish_access(1'b1);
      else if (m_wait == int'(TMO) - 1) finish_access(1'b0);
      else m_wait++;
    end
  endtask

  // Drive the memory side, sample away from the edge, compare, advance one cycle.
  task automatic tick();
    if (mem_req) begin
      mem_ack = (req_age == ack_delay);
      mem_rdata = mem_ack ? mem_rd(mem_addr) : (32'hBAD0_0000 | 32'(cyc));
      req_age++;
    end else begin
      req_age = 0;
      mem_ack = spurious;
      mem_rdata = 32'hFEED_F00D;
    end
    #1;
    seen_if_ack = if_ack; seen_dm_ack = dm_ack; last_obs = cyc;
    if (mem_req && !prev_mem_req) begin
      rise_addr.push_back(mem_addr); rise_wdata.push_back(mem_wdata);
      rise_we.push_back(mem_we); rise_size.push_back(mem_size); rise_cyc.push_back(cyc);
    end
    prev_mem_req = mem_req;
    compare_all();
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int port, input int budget, output int at);
    int i;
    at = -1; i = 0;
    while (at < 0 && i < budget) begin
      tick();
      if ((port == 1 && seen_if_ack) || (port == 2 && seen_dm_ack)) at = last_obs;
      i++;
    end
    checks++;
    if (at < 0) begin
      failures++;
      $display("FAIL wait_ack port=%0d no ack within %0d cycles", port, budget);
    end
  endtask

  task automatic clear_log();
    rise_addr.delete(); rise_wdata.delete(); rise_we.delete(); rise_size.delete(); rise_cyc.delete();
  endtask

  initial begin
    int n0, at, at2, n, acks;
    int exp_pat[10];
    exp_pat = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    reset = 1'b0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; dm_size = '0; dm_unsigned = 0; mem_ack = 0; mem_rdata = '0;
    prev_mem_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_acks", 32'({if_ack, dm_ack}), 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata | mem_addr, 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    reset = 1'b1;

    // Fetch with same-cycle memory ack.
    clear_log(); ack_delay = 0;
    if_req = 1; if_addr = 32'h10; n0 = cyc;
    wait_ack(1, 10, at);
    if_req = 0;
    chk("t1_latency", 32'(at - n0), 32'd2);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    chk("t1_mem_we", 32'(rise_we[0]), 32'h0);
    chk("t1_mem_size", 32'(rise_size[0]), 32'h2);
    tick(); tick();

    // Simultaneous fetch and store: data port first.
    clear_log(); ack_delay = 1;
    if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_size = 3'b010;
    wait_ack(2, 10, at);
    dm_req = 0; dm_we = 0;
    wait_ack(1, 10, at2);
    if_req = 0;
    chk("t2_rises", 32'(rise_addr.size()), 32'd2);
    chk("t2_first_addr", rise_addr[0], 32'h40);
    chk("t2_first_we", 32'(rise_we[0]), 32'h1);
    chk("t2_first_wdata", rise_wdata[0], 32'hDEAD_BEEF);
    chk("t2_second_addr", rise_addr[1], 32'h20);
    chk("t2_store_keeps_rdata", dm_rdata, 32'h0);
    chk("t2_if_rdata", if_rdata, 32'h0020_FFDF);
    tick(); tick();

    // Continuous loads with a pending fetch: streak limit forces fetches.
    clear_log(); ack_delay = 0;
    if_req = 1; if_addr = 32'h100;
    dm_req = 1; dm_addr = 32'h200; dm_size = 3'b010;
    n = 0;
    while (rise_addr.size() < 10 && n < 80) begin
      tick();
      if (seen_dm_ack) dm_addr = dm_addr + 32'd4;
      if (seen_if_ack) if_addr = if_addr + 32'd4;
      n++;
    end
    chk("t3_rises", 32'(rise_addr.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t3_grant%0d", i), 32'(rise_addr[i] >= 32'h200 ? 2 : 1), 32'(exp_pat[i]));
    chk("t3_if_addr5", rise_addr[4], 32'h100);
    chk("t3_dm_addr6", rise_addr[5], 32'h210);
    if_req = 0; dm_req = 0;
    repeat (6) tick();

    // Memory never answers: watchdog abort.
    clear_log(); ack_delay = 255;
    dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    wait_ack(2, 100, at);
    dm_req = 0;
    chk("t4_abort_latency", 32'(at - rise_cyc[0]), 32'd64);
    chk("t4_dm_rdata", dm_rdata, 32'h0);
    chk("t4_timeout_err", 32'(timeout_err), 32'h1);
    tick(); tick();

    // Delayed load ack, spurious acks while idle, fetch port quiet.
    clear_log(); ack_delay = 5; spurious = 1;
    dm_req = 1; dm_addr = 32'h44; dm_size = 3'b001; dm_unsigned = 1;
    wait_ack(2, 20, at);
    dm_req = 0; dm_unsigned = 0;
    chk("t5_latency", 32'(at - rise_cyc[0]), 32'd6);
    chk("t5_dm_rdata", dm_rdata, 32'h0044_FFBB);
    chk("t5_timeout_sticky", 32'(timeout_err), 32'h1);
    chk("t5_if_stall", 32'(if_stall), 32'h0);
    repeat (3) tick();
    spurious = 0;

    // Reset asserted mid-access.
    clear_log(); ack_delay = 255;
    dm_req = 1; dm_addr = 32'h60;
    tick(); tick();
    chk("t6_busy", 32'(mem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_mem_req", 32'(mem_req), 32'h0);
    chk("t6_async_timeout_err", 32'(timeout_err), 32'h0);
    dm_req = 0; model_reset(); prev_mem_req = 0;
    @(negedge clk);
    reset = 1'b1;
    acks = 0;
    repeat (6) begin
      tick();
      if (seen_dm_ack) acks++;
    end
    chk("t6_no_ack_after_reset", 32'(acks), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "bench time limit");
  end
endmodule
